// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial LSB-first A - B sequencer with start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic borrow_q, borrow_d, borrow_out_q, borrow_out_d;
  logic hs_d, hs_bw, d_bit, bw;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  // Full subtractor as two cascaded half subtractors: (a - b) then (that - borrow).
  assign hs_d  = a_sh_q[0] ^ b_sh_q[0];
  assign hs_bw = ~a_sh_q[0] & b_sh_q[0];
  assign d_bit = hs_d ^ borrow_q;
  assign bw    = hs_bw | (~hs_d & borrow_q);
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        a_sh_d   = a;
        b_sh_d   = b;
        res_d    = '0;
        cnt_d    = '0;
        borrow_d = 1'b0;
        state_d  = RUN;
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = bw;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = DONE;
          diff_d       = {d_bit, res_q[WIDTH-1:1]};
          borrow_out_d = bw;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit the shift registers still hold the operand MSBs.
          ovf_d        = hs_d & (a_sh_q[0] ^ d_bit);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end
endmodule
